// File: rtl/mem_io_arbiter.sv
// Two-requester round-robin arbiter onto a shared memory/IO bus.
// Each granted access runs for a fixed latency (memory or IO) and is
// completed with a one-cycle ack and, for reads, a registered rdata.
module mem_io_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned IO_LAT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_memread,
    output logic        bus_memwrite,
    output logic        bus_ioread,
    output logic        bus_iowrite,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] MEM_CNT = 4'(MEM_LAT - 1);
    localparam logic [3:0] IO_CNT  = 4'(IO_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last;       // requester granted most recently
    logic        gnt;        // requester owning the current access
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we;
    logic        a_io;

    logic        grant_en;
    logic        grant_sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        sel_io;
    logic        finish;
    logic [31:0] rd_val;

    // Operand mux for the requester about to be granted.
    always_comb begin
        sel_addr  = grant_sel ? addr1  : addr0;
        sel_wdata = grant_sel ? wdata1 : wdata0;
        sel_we    = grant_sel ? we1    : we0;
        sel_io    = &sel_addr[31:10];
        finish    = (state == ACCESS) && (cnt == 4'd0);
        rd_val    = a_io ? {16'h0, bus_rdata[15:0]} : bus_rdata;
    end

    // Next-state logic and round-robin grant decision.
    always_comb begin
        state_nxt = state;
        grant_en  = 1'b0;
        grant_sel = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_en  = 1'b1;
                    grant_sel = (req0 && req1) ? ~last : req1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Access latch, latency counter, round-robin pointer and read data capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            last    <= 1'b1;
            gnt     <= 1'b0;
            a_addr  <= '0;
            a_wdata <= '0;
            a_we    <= 1'b0;
            a_io    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            if (grant_en) begin
                gnt     <= grant_sel;
                last    <= grant_sel;
                a_addr  <= sel_addr;
                a_wdata <= sel_wdata;
                a_we    <= sel_we;
                a_io    <= sel_io;
                cnt     <= sel_io ? IO_CNT : MEM_CNT;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (finish && !a_we) begin
                if (gnt) begin
                    rdata1 <= rd_val;
                end else begin
                    rdata0 <= rd_val;
                end
            end
        end
    end

    // Bus strobes, bus operands and completion pulses decoded from state.
    always_comb begin
        bus_addr     = '0;
        bus_wdata    = '0;
        bus_memread  = 1'b0;
        bus_memwrite = 1'b0;
        bus_ioread   = 1'b0;
        bus_iowrite  = 1'b0;
        if (state == ACCESS) begin
            bus_addr     = a_addr;
            bus_memread  = !a_io && !a_we;
            bus_memwrite = !a_io &&  a_we;
            bus_ioread   =  a_io && !a_we;
            bus_iowrite  =  a_io &&  a_we;
            if (a_we) begin
                bus_wdata = a_io ? {16'h0, a_wdata[15:0]} : a_wdata;
            end
        end
        ack0 = (state == DONE) && !gnt;
        ack1 = (state == DONE) &&  gnt;
    end

endmodule
